// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit word load/store to a 16-bit external SRAM.
// Each word access is split into two half accesses, low half then high half.
// Each half is held on the bus for WAIT_CYCLES cycles. One DONE cycle follows,
// during which ready is asserted.
//
// Ports:
//   clk, rst           system clock (rising edge), synchronous active-high reset
//   wr_en, rd_en       word write / read request, sampled only while idle
//   address            byte address; BASE_ADDR maps to SRAM word 0
//   writeData          store data
//   readData           registered load data, updated when a read completes
//   ready              combinational; low while an access is outstanding
//   sram_addr          half-word address to the SRAM
//   sram_dq_out/oe     write data and its drive enable
//   sram_dq_in         read data from the SRAM
//   sram_we_n          SRAM write enable, active low
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned WAW = SRAM_AW - 1;
    localparam int unsigned CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           is_wr, is_wr_n;
    logic [WAW-1:0] word, word_n;
    logic [31:0]    wd, wd_n;
    logic [15:0]    lo, lo_n;
    logic [31:0]    rdata_n;
    logic [WAW-1:0] req_word;
    logic           req;
    logic           last;

    // Word index relative to BASE_ADDR; the byte offset bits and any bits
    // above the SRAM range fall away, so the address wraps.
    assign req_word = WAW'((address - 32'(BASE_ADDR)) >> 2);
    assign req      = wr_en | rd_en;
    assign last     = (cnt == CW'(WAIT_CYCLES - 1));
    assign ready    = ((state == S_IDLE) && !req) || (state == S_DONE);

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        is_wr_n = is_wr;
        word_n  = word;
        wd_n    = wd;
        lo_n    = lo;
        rdata_n = readData;
        case (state)
            S_IDLE: begin
                if (req) begin
                    is_wr_n = wr_en;
                    word_n  = req_word;
                    wd_n    = writeData;
                    cnt_n   = '0;
                    state_n = S_LOW;
                end
            end
            S_LOW: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = S_HIGH;
                    if (!is_wr) lo_n = sram_dq_in;
                end else begin
                    cnt_n = CW'(cnt + 1'b1);
                end
            end
            S_HIGH: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = S_DONE;
                    if (!is_wr) rdata_n = {sram_dq_in, lo};
                end else begin
                    cnt_n = CW'(cnt + 1'b1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_wr    <= 1'b0;
            word     <= '0;
            wd       <= '0;
            lo       <= '0;
            readData <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            is_wr    <= is_wr_n;
            word     <= word_n;
            wd       <= wd_n;
            lo       <= lo_n;
            readData <= rdata_n;
        end
    end

    // Bus drive, decoded from registered state only
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (state == S_LOW || state == S_HIGH) begin
            sram_addr = {word, (state == S_HIGH)};
            if (is_wr) begin
                sram_dq_out = (state == S_HIGH) ? wd[31:16] : wd[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: self-checking bench for sram_controller with a
// combinational-read SRAM model and a queue of expected load results.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    // backdoor preload port into the SRAM model
    logic        bd_we;
    logic [17:0] bd_addr;
    logic [15:0] bd_data;

    logic [15:0] mem [0:262143];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] rd_model;

    // per-cycle observations of one access
    logic [17:0] o_addr  [0:7];
    logic [15:0] o_dq    [0:7];
    logic        o_we_n  [0:7];
    logic        o_oe    [0:7];
    logic        o_ready [0:7];
    logic [31:0] o_rd    [0:7];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData), .readData(readData),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    assign sram_dq_in = mem[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    // Apply a request in the current IDLE cycle and record ncyc cycles.
    // After cycle 0 the address switches to a2; the request lines drop
    // unless keep is set.
    task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] a2,
                         input int ncyc, input bit keep);
        wr_en = wr; rd_en = rd; address = a; writeData = d;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            o_addr[c] = sram_addr; o_dq[c] = sram_dq_out; o_we_n[c] = sram_we_n;
            o_oe[c] = sram_dq_oe; o_ready[c] = ready; o_rd[c] = readData;
            @(posedge clk); #1;
            address = a2;
            if (!keep) begin wr_en = 1'b0; rd_en = 1'b0; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; writeData = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", sram_dq_oe); end
        n_cmp++; if (readData !== 32'h0) begin n_err++; $display("FAIL reset_readData: got %h want 0", readData); end
        rd_model = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        logic [17:0] ea; logic [15:0] ed; logic act;
        issue(1'b1, 1'b0, 32'd1028, 32'h12345678, 32'd1028, 6, 1'b0);
        for (int c = 0; c < 6; c++) begin
            act = (c >= 1 && c <= 4);
            ea  = (c == 1 || c == 2) ? 18'h2 : (c == 3 || c == 4) ? 18'h3 : 18'h0;
            ed  = (c == 1 || c == 2) ? 16'h5678 : (c == 3 || c == 4) ? 16'h1234 : 16'h0;
            n_cmp++; if (o_addr[c] !== ea) begin n_err++; $display("FAIL wr_addr c%0d: got %h want %h", c, o_addr[c], ea); end
            n_cmp++; if (o_dq[c] !== ed) begin n_err++; $display("FAIL wr_dq c%0d: got %h want %h", c, o_dq[c], ed); end
            n_cmp++; if (o_we_n[c] !== !act) begin n_err++; $display("FAIL wr_we_n c%0d: got %b want %b", c, o_we_n[c], !act); end
            n_cmp++; if (o_oe[c] !== act) begin n_err++; $display("FAIL wr_oe c%0d: got %b want %b", c, o_oe[c], act); end
            n_cmp++; if (o_ready[c] !== (c == 5)) begin n_err++; $display("FAIL wr_ready c%0d: got %b want %b", c, o_ready[c], (c == 5)); end
        end
        n_cmp++; if (mem[2] !== 16'h5678) begin n_err++; $display("FAIL wr_mem2: got %h want 5678", mem[2]); end
        n_cmp++; if (mem[3] !== 16'h1234) begin n_err++; $display("FAIL wr_mem3: got %h want 1234", mem[3]); end
    endtask

    task automatic test_read();
        logic [31:0] exp;
        logic [17:0] ea;
        exp_q.push_back(32'h12345678);
        issue(1'b0, 1'b1, 32'd1028, 32'h0, 32'd1028, 6, 1'b0);
        for (int c = 0; c < 6; c++) begin
            ea = (c == 1 || c == 2) ? 18'h2 : (c == 3 || c == 4) ? 18'h3 : 18'h0;
            n_cmp++; if (o_addr[c] !== ea) begin n_err++; $display("FAIL rd_addr c%0d: got %h want %h", c, o_addr[c], ea); end
            n_cmp++; if (o_we_n[c] !== 1'b1 || o_oe[c] !== 1'b0) begin n_err++; $display("FAIL rd_bus c%0d: got we_n=%b oe=%b want 1/0", c, o_we_n[c], o_oe[c]); end
            n_cmp++; if (o_ready[c] !== (c == 5)) begin n_err++; $display("FAIL rd_ready c%0d: got %b want %b", c, o_ready[c], (c == 5)); end
        end
        n_cmp++; if (o_rd[4] !== rd_model) begin n_err++; $display("FAIL rd_early: got %h want %h", o_rd[4], rd_model); end
        exp = exp_q.pop_front();
        n_cmp++; if (o_rd[5] !== exp) begin n_err++; $display("FAIL rd_data: got %h want %h", o_rd[5], exp); end
        rd_model = exp;
    endtask

    task automatic test_both();
        logic [31:0] exp;
        exp_q.push_back(rd_model);
        issue(1'b1, 1'b1, 32'd1032, 32'hCAFEBABE, 32'd1032, 6, 1'b0);
        n_cmp++; if (mem[4] !== 16'hBABE) begin n_err++; $display("FAIL both_mem4: got %h want babe", mem[4]); end
        n_cmp++; if (mem[5] !== 16'hCAFE) begin n_err++; $display("FAIL both_mem5: got %h want cafe", mem[5]); end
        n_cmp++; if (o_ready[5] !== 1'b1) begin n_err++; $display("FAIL both_ready: got %b want 1", o_ready[5]); end
        exp = exp_q.pop_front();
        n_cmp++; if (o_rd[5] !== exp) begin n_err++; $display("FAIL both_readData: got %h want %h", o_rd[5], exp); end
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; address = 32'd1036; writeData = 32'hDEADBEEF;
        @(posedge clk); #1 wr_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL mid_active: got we_n=%b want 0", sram_we_n); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL mid_we_n: got %b want 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL mid_oe: got %b want 0", sram_dq_oe); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", ready); end
        n_cmp++; if (sram_addr !== 18'h0) begin n_err++; $display("FAIL mid_addr: got %h want 0", sram_addr); end
        n_cmp++; if (readData !== 32'h0) begin n_err++; $display("FAIL mid_readData: got %h want 0", readData); end
        rd_model = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic [17:0] ea;
        bd_we = 1'b1; bd_addr = 18'h0; bd_data = 16'h1111;
        @(posedge clk); #1 bd_addr = 18'h1; bd_data = 16'h2222;
        @(posedge clk); #1 bd_we = 1'b0;
        exp_q.push_back(32'h22221111);
        exp_q.push_back(32'h12345678);
        issue(1'b0, 1'b1, 32'd1024 + 32'd4 * (32'd1 << 17), 32'h0, 32'd1028, 6, 1'b1);
        for (int c = 1; c < 5; c++) begin
            ea = (c >= 3) ? 18'h1 : 18'h0;
            n_cmp++; if (o_addr[c] !== ea) begin n_err++; $display("FAIL wrap_addr c%0d: got %h want %h", c, o_addr[c], ea); end
        end
        exp = exp_q.pop_front();
        n_cmp++; if (o_rd[5] !== exp) begin n_err++; $display("FAIL wrap_data: got %h want %h", o_rd[5], exp); end
        issue(1'b0, 1'b1, 32'd1028, 32'h0, 32'd1028, 6, 1'b0);
        n_cmp++; if (o_ready[0] !== 1'b0) begin n_err++; $display("FAIL b2b_idle_ready: got %b want 0", o_ready[0]); end
        n_cmp++; if (o_addr[1] !== 18'h2 || o_addr[3] !== 18'h3) begin n_err++; $display("FAIL b2b_addr: got %h/%h want 2/3", o_addr[1], o_addr[3]); end
        n_cmp++; if (o_ready[5] !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", o_ready[5]); end
        exp = exp_q.pop_front();
        n_cmp++; if (o_rd[5] !== exp) begin n_err++; $display("FAIL b2b_data: got %h want %h", o_rd[5], exp); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
